calc_entry_ctrl: RTL and testbench

//  Parametrised operand-entry controller for the calculator keypad front end.

---
 rtl/calc_pkg.sv | 45 ++++
 rtl/calc_digit_counter.sv | 40 ++++
 rtl/calc_entry_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator keypad entry controller.
// Holds the FSM state encoding, the key strobe priority resolver and a clog2 helper.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_LOCK   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    // Listed lowest to highest priority.
    typedef enum logic [2:0] {
        KEY_NONE = 3'd0,
        KEY_OP   = 3'd1,
        KEY_DIG  = 3'd2,
        KEY_BKSP = 3'd3,
        KEY_EQ   = 3'd4,
        KEY_CLR  = 3'd5
    } key_e;

    function automatic int calc_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // The single strongest strobe wins, even when its own action is then ignored.
    function automatic key_e key_pick(input logic clr, input logic eq, input logic bksp,
                                      input logic dig, input logic op);
        key_e k;
        if (clr)       k = KEY_CLR;
        else if (eq)   k = KEY_EQ;
        else if (bksp) k = KEY_BKSP;
        else if (dig)  k = KEY_DIG;
        else if (op)   k = KEY_OP;
        else           k = KEY_NONE;
        return k;
    endfunction

endpackage

// File: rtl/calc_digit_counter.sv
// Per-operand saturating digit counter (clr > set_full > dec > inc).
// Latency: count registers on the next edge; count_nxt exposes the pending value combinationally.
// Backpressure: none; inc at full and dec at empty are absorbed by saturation.
module calc_digit_counter #(
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             set_full,
    output logic [CNT_W-1:0] count_nxt,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] count_q;

    assign full  = (count_q == CNT_W'(MAX_DIGITS));
    assign empty = (count_q == '0);

    always_comb begin
        count_nxt = count_q;
        if (clr)                count_nxt = '0;
        else if (set_full)      count_nxt = CNT_W'(MAX_DIGITS);
        else if (dec && !empty) count_nxt = count_q - CNT_W'(1);
        else if (inc && !full)  count_nxt = count_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Operand-entry controller: turns keypad strobes into operand load/clear/chain/result pulses.
// Latency: every output is registered, responding one cycle after the strobe is sampled.
// Backpressure: none; strobes arriving in LOCK (except clear) or disallowed in RESULT are dropped.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int NUM_OPERANDS = 2,
    parameter int MAX_DIGITS   = 4,
    parameter int KEY_W        = 4,
    parameter int SEL_W        = calc_clog2(NUM_OPERANDS + 1),
    parameter int CNT_W        = calc_clog2(MAX_DIGITS + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    dig_in,
    input  logic                    op_in,
    input  logic                    bksp_in,
    input  logic                    clr_in,
    input  logic                    eq_in,
    input  logic [KEY_W-1:0]        keycode,
    output logic [NUM_OPERANDS-1:0] load,
    output logic [NUM_OPERANDS-1:0] bksp,
    output logic [NUM_OPERANDS-1:0] clear,
    output logic                    chain,
    output logic                    result_req,
    output logic                    overflow,
    output logic [KEY_W-1:0]        op_code,
    output logic [SEL_W-1:0]        display_select,
    output logic [CNT_W-1:0]        digit_count
);

    state_e                  state, state_nxt;
    key_e                    key;
    logic [SEL_W-1:0]        sel, sel_nxt;
    logic [KEY_W-1:0]        op_nxt;
    logic [NUM_OPERANDS-1:0] load_nxt, bksp_nxt, clear_nxt;
    logic                    chain_nxt, req_nxt, ovf_nxt;
    logic [SEL_W-1:0]        disp_nxt;
    logic [CNT_W-1:0]        dc_nxt;

    logic [NUM_OPERANDS-1:0] cnt_inc, cnt_dec, cnt_clr, cnt_set;
    logic [NUM_OPERANDS-1:0] is_full, is_empty;
    logic [CNT_W-1:0]        cnt_nxt [NUM_OPERANDS];
    logic [NUM_OPERANDS-1:0] sel_onehot;
    logic                    sel_full, sel_empty;

    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_cnt
        calc_digit_counter #(
            .MAX_DIGITS (MAX_DIGITS),
            .CNT_W      (CNT_W)
        ) u_cnt (
            .clock     (clock),
            .reset_n   (reset_n),
            .inc       (cnt_inc[g]),
            .dec       (cnt_dec[g]),
            .clr       (cnt_clr[g]),
            .set_full  (cnt_set[g]),
            .count_nxt (cnt_nxt[g]),
            .full      (is_full[g]),
            .empty     (is_empty[g])
        );
    end

    assign sel_onehot = NUM_OPERANDS'(1) << sel;

    always_comb begin
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_full  = is_full[i];
                sel_empty = is_empty[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        op_nxt    = op_code;
        load_nxt  = '0;
        bksp_nxt  = '0;
        clear_nxt = '0;
        chain_nxt = 1'b0;
        req_nxt   = 1'b0;
        ovf_nxt   = 1'b0;
        cnt_inc   = '0;
        cnt_dec   = '0;
        cnt_clr   = '0;
        cnt_set   = '0;
        key       = key_pick(clr_in, eq_in, bksp_in, dig_in, op_in);

        if (key == KEY_CLR) begin
            clear_nxt = '1;
            cnt_clr   = '1;
            sel_nxt   = '0;
            state_nxt = ST_ENTRY;
        end else begin
            case (state)
                ST_LOCK: state_nxt = ST_ENTRY;
                ST_ENTRY: begin
                    case (key)
                        KEY_EQ: begin
                            req_nxt   = 1'b1;
                            state_nxt = ST_RESULT;
                        end
                        KEY_BKSP: begin
                            if (!sel_empty) begin
                                load_nxt  = sel_onehot;
                                bksp_nxt  = sel_onehot;
                                cnt_dec   = sel_onehot;
                                state_nxt = ST_LOCK;
                            end
                        end
                        KEY_DIG: begin
                            if (sel_full) begin
                                ovf_nxt = 1'b1;
                            end else begin
                                load_nxt  = sel_onehot;
                                cnt_inc   = sel_onehot;
                                state_nxt = ST_LOCK;
                            end
                        end
                        KEY_OP: begin
                            op_nxt  = keycode;
                            sel_nxt = (sel == SEL_W'(NUM_OPERANDS - 1)) ? '0 : sel + SEL_W'(1);
                        end
                        default: ;
                    endcase
                end
                ST_RESULT: begin
                    case (key)
                        KEY_DIG: begin
                            clear_nxt = '1;
                            cnt_clr   = '1;
                            sel_nxt   = '0;
                            state_nxt = ST_ENTRY;
                        end
                        // Result becomes operand 0 (already "full"); later operands start fresh.
                        KEY_OP: begin
                            chain_nxt = 1'b1;
                            op_nxt    = keycode;
                            cnt_set   = NUM_OPERANDS'(1);
                            cnt_clr   = ~NUM_OPERANDS'(1);
                            clear_nxt = ~NUM_OPERANDS'(1);
                            sel_nxt   = SEL_W'(1);
                            state_nxt = ST_ENTRY;
                        end
                        default: ;
                    endcase
                end
                default: state_nxt = ST_ENTRY;
            endcase
        end
    end

    // Display reflects the post-edge state so it lines up with the registered pulses.
    always_comb begin
        disp_nxt = sel_nxt;
        dc_nxt   = '0;
        if (state_nxt == ST_RESULT) begin
            disp_nxt = SEL_W'(NUM_OPERANDS);
        end else begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (sel_nxt == SEL_W'(i)) begin
                    dc_nxt = cnt_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_ENTRY;
            sel            <= '0;
            op_code        <= '0;
            load           <= '0;
            bksp           <= '0;
            clear          <= '0;
            chain          <= 1'b0;
            result_req     <= 1'b0;
            overflow       <= 1'b0;
            display_select <= '0;
            digit_count    <= '0;
        end else begin
            state          <= state_nxt;
            sel            <= sel_nxt;
            op_code        <= op_nxt;
            load           <= load_nxt;
            bksp           <= bksp_nxt;
            clear          <= clear_nxt;
            chain          <= chain_nxt;
            result_req     <= req_nxt;
            overflow       <= ovf_nxt;
            display_select <= disp_nxt;
            digit_count    <= dc_nxt;
        end
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl (NUM_OPERANDS=2, MAX_DIGITS=4): expected output
// records are queued when a key is driven and compared when the registered response appears.
module tb_calc_entry_ctrl;

    logic       clock;
    logic       reset_n;
    logic       dig_in, op_in, bksp_in, clr_in, eq_in;
    logic [3:0] keycode;
    logic [1:0] load, bksp, clear;
    logic       chain, result_req, overflow;
    logic [3:0] op_code;
    logic [1:0] display_select;
    logic [2:0] digit_count;

    typedef struct packed {
        logic [1:0] load;
        logic [1:0] bksp;
        logic [1:0] clear;
        logic       chain;
        logic       req;
        logic       ovf;
        logic [3:0] op;
        logic [1:0] disp;
        logic [2:0] dc;
    } exp_t;

    // Strobe vector order: {clr, eq, bksp, dig, op}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_OP   = 5'b00001;
    localparam logic [4:0] S_DIG  = 5'b00010;
    localparam logic [4:0] S_BK   = 5'b00100;
    localparam logic [4:0] S_EQ   = 5'b01000;
    localparam logic [4:0] S_CLR  = 5'b10000;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    calc_entry_ctrl #(
        .NUM_OPERANDS (2),
        .MAX_DIGITS   (4),
        .KEY_W        (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .dig_in         (dig_in),
        .op_in          (op_in),
        .bksp_in        (bksp_in),
        .clr_in         (clr_in),
        .eq_in          (eq_in),
        .keycode        (keycode),
        .load           (load),
        .bksp           (bksp),
        .clear          (clear),
        .chain          (chain),
        .result_req     (result_req),
        .overflow       (overflow),
        .op_code        (op_code),
        .display_select (display_select),
        .digit_count    (digit_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic exp_t ex(input logic [1:0] ld, input logic [1:0] bk, input logic [1:0] cl,
                                input logic ch, input logic rq, input logic ov,
                                input logic [3:0] op, input logic [1:0] disp, input logic [2:0] dc);
        exp_t e;
        e.load = ld; e.bksp = bk; e.clear = cl; e.chain = ch; e.req = rq; e.ovf = ov;
        e.op = op; e.disp = disp; e.dc = dc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_next(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, observed output with no expectation", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".load"},  16'(load),           16'(e.load));
            chk({tag, ".bksp"},  16'(bksp),           16'(e.bksp));
            chk({tag, ".clear"}, 16'(clear),          16'(e.clear));
            chk({tag, ".chain"}, 16'(chain),          16'(e.chain));
            chk({tag, ".req"},   16'(result_req),     16'(e.req));
            chk({tag, ".ovf"},   16'(overflow),       16'(e.ovf));
            chk({tag, ".op"},    16'(op_code),        16'(e.op));
            chk({tag, ".disp"},  16'(display_select), 16'(e.disp));
            chk({tag, ".dc"},    16'(digit_count),    16'(e.dc));
        end
    endtask

    task automatic step(input string tag, input logic [4:0] s, input logic [3:0] kc, input exp_t e);
        @(negedge clock);
        {clr_in, eq_in, bksp_in, dig_in, op_in} = s;
        keycode = kc;
        sb.push_back(e);
        @(posedge clock);
        #1;
        {clr_in, eq_in, bksp_in, dig_in, op_in} = S_NONE;
        keycode = 4'd0;
        check_next(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        {clr_in, eq_in, bksp_in, dig_in, op_in} = S_NONE;
        keycode = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        sb.push_back(ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd0));
        check_next("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Fill operand 0 to the limit; the fifth digit overflows.
        step("d1",   S_DIG,  4'd1, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd1));
        step("i1",   S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd1));
        step("d2",   S_DIG,  4'd2, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd2));
        step("i2",   S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd2));
        step("d3",   S_DIG,  4'd3, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd3));
        step("i3",   S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd3));
        step("d4",   S_DIG,  4'd4, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd4));
        step("i4",   S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd4));
        step("d5ov", S_DIG,  4'd5, ex(2'b00, 2'b00, 2'b00, 0, 0, 1, 4'd0, 2'd0, 3'd4));

        // Reset asserted while the FSM sits in LOCK.
        step("clr0", S_CLR,  4'd0, ex(2'b00, 2'b00, 2'b11, 0, 0, 0, 4'd0, 2'd0, 3'd0));
        step("dlk",  S_DIG,  4'd6, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd1));
        @(negedge clock);
        reset_n = 1'b0;
        sb.push_back(ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd0));
        @(posedge clock);
        #1;
        check_next("rst_lock");
        @(negedge clock);
        reset_n = 1'b1;

        // Operand switch; a digit arriving in LOCK is dropped.
        step("a1",   S_DIG,  4'd1, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd1));
        step("alck", S_DIG,  4'd2, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd0, 2'd0, 3'd1));
        step("op3",  S_OP,   4'd3, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd1, 3'd0));
        step("b1",   S_DIG,  4'd7, ex(2'b10, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd1, 3'd1));
        step("bi",   S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd1, 3'd1));

        // Backspace at zero is ignored; otherwise it decrements.
        step("clr1", S_CLR,  4'd0, ex(2'b00, 2'b00, 2'b11, 0, 0, 0, 4'd3, 2'd0, 3'd0));
        step("bk0",  S_BK,   4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd0));
        step("e1",   S_DIG,  4'd1, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd1));
        step("ei1",  S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd1));
        step("e2",   S_DIG,  4'd2, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd2));
        step("ei2",  S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd2));
        step("bk2",  S_BK,   4'd0, ex(2'b01, 2'b01, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd1));
        step("bki",  S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd1));

        // Coincident strobes resolve by priority.
        step("pri1", S_DIG | S_OP | S_BK, 4'd9,
             ex(2'b01, 2'b01, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd0));
        step("pri1i", S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd3, 2'd0, 3'd0));
        step("pri2", S_CLR | S_EQ, 4'd0,
             ex(2'b00, 2'b00, 2'b11, 0, 0, 0, 4'd3, 2'd0, 3'd0));

        // Operator on the last operand wraps the selection to 0.
        step("op7",  S_OP,   4'd7, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd7, 2'd1, 3'd0));
        step("op2w", S_OP,   4'd2, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd2, 2'd0, 3'd0));

        // Result view, ignored keys there, and chaining.
        step("f1",   S_DIG,  4'd1, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd2, 2'd0, 3'd1));
        step("fi",   S_NONE, 4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd2, 2'd0, 3'd1));
        step("eq",   S_EQ,   4'd0, ex(2'b00, 2'b00, 2'b00, 0, 1, 0, 4'd2, 2'd2, 3'd0));
        step("rbk",  S_BK,   4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd2, 2'd2, 3'd0));
        step("req",  S_EQ,   4'd0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd2, 2'd2, 3'd0));
        step("chn",  S_OP,   4'd5, ex(2'b00, 2'b00, 2'b10, 1, 0, 0, 4'd5, 2'd1, 3'd0));
        step("wr0",  S_OP,   4'd1, ex(2'b00, 2'b00, 2'b00, 0, 0, 0, 4'd1, 2'd0, 3'd4));
        step("ovf0", S_DIG,  4'd8, ex(2'b00, 2'b00, 2'b00, 0, 0, 1, 4'd1, 2'd0, 3'd4));
        step("eq2",  S_EQ,   4'd0, ex(2'b00, 2'b00, 2'b00, 0, 1, 0, 4'd1, 2'd2, 3'd0));
        step("rdig", S_DIG,  4'd4, ex(2'b00, 2'b00, 2'b11, 0, 0, 0, 4'd1, 2'd0, 3'd0));
        step("post", S_DIG,  4'd4, ex(2'b01, 2'b00, 2'b00, 0, 0, 0, 4'd1, 2'd0, 3'd1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
